// File: rtl/wb_vec_collector.sv
// -----------------------------------------------------------------------------
// wb_vec_collector
//
// Write-back stage helper. It always drives the scalar register-file write port
// straight from the MEM/WB pipeline register. When vector collection is built
// in, it also gathers four 32-bit write-back beats into one 128-bit word and
// commits that word to the vector register file as a single write.
//
// Build option:
//   WB_VEC_COLLECT_EN  defined   -> vector collector present
//                      undefined -> WVRwrite_in/SVRwrite_in are ignored and
//                                   every vector output is tied to 0
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   readdata_in    MEM/WB load data (32)
//   alu_result_in  MEM/WB ALU result (32)
//   rd_in          MEM/WB destination index (5)
//   memtoreg_in    selects load data (1) or ALU result (0) as write-back data
//   regwrite_in    scalar register write request
//   WVRwrite_in    vector beat destined for the WVR file
//   SVRwrite_in    vector beat destined for the SVR file
//   rf_we/rf_waddr/rf_wdata               scalar RF write port (combinational)
//   vr_we/vr_sel/vr_waddr/vr_wdata        vector RF write port (registered,
//                                         vr_sel 0=WVR 1=SVR)
//   vr_busy        high while a partial vector is held
//   vr_err         sticky sequence-violation flag, cleared only by reset
// -----------------------------------------------------------------------------
module wb_vec_collector (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  readdata_in,
  input  logic [31:0]  alu_result_in,
  input  logic [4:0]   rd_in,
  input  logic         memtoreg_in,
  input  logic         regwrite_in,
  input  logic         WVRwrite_in,
  input  logic         SVRwrite_in,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic         vr_we,
  output logic         vr_sel,
  output logic [4:0]   vr_waddr,
  output logic [127:0] vr_wdata,
  output logic         vr_busy,
  output logic         vr_err
);

  // ---------------------------------------------------------------------------
  // Write-back data select and scalar port (zero latency)
  // ---------------------------------------------------------------------------
  logic [31:0] wb_data;

  assign wb_data  = memtoreg_in ? readdata_in : alu_result_in;

  // x0 is hard-wired zero in the scalar file, so writes to it are dropped.
  assign rf_we    = regwrite_in && (rd_in != 5'd0);
  assign rf_waddr = rd_in;
  assign rf_wdata = wb_data;

`ifdef WB_VEC_COLLECT_EN

  // ---------------------------------------------------------------------------
  // Vector collector
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE    = 1'b0,   // beat count 0
    S_COLLECT = 1'b1    // beat count 1..3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]   cnt_q,   cnt_d;     // index of the next beat to store
  logic [127:0] buf_q,   buf_d;     // staging buffer, beat k in [32k+31:32k]
  logic         type_q,  type_d;    // latched vector type (0=WVR, 1=SVR)
  logic [4:0]   rd_q,    rd_d;      // latched destination index
  logic         we_q,    we_d;
  logic         sel_q,   sel_d;
  logic [4:0]   waddr_q, waddr_d;
  logic [127:0] wdata_q, wdata_d;
  logic         err_q,   err_d;

  // Beat classification for the current cycle.
  logic beat_valid;     // exactly one vector flag high
  logic both_flags;     // both flags high: illegal, beat ignored
  logic beat_type;      // 1 when the beat targets the SVR file
  logic seq_mismatch;   // beat does not belong to the sequence in progress

  assign beat_valid   = WVRwrite_in ^ SVRwrite_in;
  assign both_flags   = WVRwrite_in & SVRwrite_in;
  assign beat_type    = SVRwrite_in;
  assign seq_mismatch = (state_q == S_COLLECT) && beat_valid &&
                        ((beat_type != type_q) || (rd_in != rd_q));

  // Decoded actions, produced by the FSM output process.
  logic start_beat;     // beat becomes beat 0 of a fresh sequence
  logic cont_beat;      // beat extends the sequence in progress
  logic last_beat;      // continuing beat that completes the vector
  logic set_err;        // sequence violation seen this cycle
  logic busy;

  // ---- FSM: state register --------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next-state logic ------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (beat_valid) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A mismatching beat restarts collection and so stays in COLLECT.
        if (beat_valid && !seq_mismatch && (cnt_q == 2'd3)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: output logic ----------------------------------------------------
  always_comb begin
    start_beat = 1'b0;
    cont_beat  = 1'b0;
    last_beat  = 1'b0;
    set_err    = both_flags;
    busy       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        start_beat = beat_valid;
      end
      S_COLLECT: begin
        busy = 1'b1;
        if (seq_mismatch) begin
          start_beat = 1'b1;
          set_err    = 1'b1;
        end else if (beat_valid) begin
          cont_beat = 1'b1;
          last_beat = (cnt_q == 2'd3);
        end
      end
      default: ;
    endcase
  end

  // ---- Datapath next-state --------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    type_d  = type_q;
    rd_d    = rd_q;
    we_d    = 1'b0;           // commit strobe lasts a single cycle
    sel_d   = sel_q;          // write-port fields hold between commits
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q | set_err;

    if (start_beat) begin
      // Any older partial data is dropped; only beat 0 survives.
      cnt_d  = 2'd1;
      buf_d  = {96'd0, wb_data};
      type_d = beat_type;
      rd_d   = rd_in;
    end else if (cont_beat) begin
      cnt_d = cnt_q + 2'd1;   // wraps 3 -> 0 on the final beat
      buf_d[{cnt_q, 5'd0} +: 32] = wb_data;
    end

    if (last_beat) begin
      // Beat 3 goes straight into the committed word rather than via buf_q.
      we_d    = 1'b1;
      sel_d   = type_q;
      waddr_d = rd_q;
      wdata_d = {wb_data, buf_q[95:0]};
    end
  end

  // ---- Datapath registers ---------------------------------------------------
  // NOTE: the staging buffer and write-data register are cleared by reset like
  // any control register; reset must leave no stale vector data visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      buf_q   <= '0;
      type_q  <= 1'b0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      type_q  <= type_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign vr_we    = we_q;
  assign vr_sel   = sel_q;
  assign vr_waddr = waddr_q;
  assign vr_wdata = wdata_q;
  assign vr_busy  = busy;
  assign vr_err   = err_q;

`else

  // ---------------------------------------------------------------------------
  // Collector not built: vector port permanently idle
  // ---------------------------------------------------------------------------
  logic unused_vec_inputs;

  assign unused_vec_inputs = ^{clk, reset, WVRwrite_in, SVRwrite_in};

  assign vr_we    = 1'b0;
  assign vr_sel   = 1'b0;
  assign vr_waddr = 5'd0;
  assign vr_wdata = '0;
  assign vr_busy  = 1'b0;
  assign vr_err   = 1'b0;

`endif

endmodule

// File: tb/tb_wb_vec_collector.sv
// -----------------------------------------------------------------------------
// tb_wb_vec_collector
//
// Directed bench for wb_vec_collector. Vector-port expectations are written
// for the collector being present; when WB_VEC_COLLECT_EN is not defined they
// collapse to 0 through vx(), since the vector port is then tied off.
// -----------------------------------------------------------------------------
module tb_wb_vec_collector;

`ifdef WB_VEC_COLLECT_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  readdata_in;
  logic [31:0]  alu_result_in;
  logic [4:0]   rd_in;
  logic         memtoreg_in;
  logic         regwrite_in;
  logic         WVRwrite_in;
  logic         SVRwrite_in;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         vr_we;
  logic         vr_sel;
  logic [4:0]   vr_waddr;
  logic [127:0] vr_wdata;
  logic         vr_busy;
  logic         vr_err;

  int checks = 0;
  int errors = 0;

  wb_vec_collector dut (
    .clk           (clk),
    .reset         (reset),
    .readdata_in   (readdata_in),
    .alu_result_in (alu_result_in),
    .rd_in         (rd_in),
    .memtoreg_in   (memtoreg_in),
    .regwrite_in   (regwrite_in),
    .WVRwrite_in   (WVRwrite_in),
    .SVRwrite_in   (SVRwrite_in),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .vr_we         (vr_we),
    .vr_sel        (vr_sel),
    .vr_waddr      (vr_waddr),
    .vr_wdata      (vr_wdata),
    .vr_busy       (vr_busy),
    .vr_err        (vr_err)
  );

  always #5 clk = ~clk;

  // Expected vector-port value: as given when the collector is built, else 0.
  function automatic logic [127:0] vx(input logic [127:0] v);
    return VEC_EN ? v : 128'd0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one vector beat (memtoreg=0, data on the ALU result) for one edge.
  task automatic beat(input logic w, input logic s, input logic [4:0] rd,
                      input logic [31:0] d);
    WVRwrite_in   = w;
    SVRwrite_in   = s;
    rd_in         = rd;
    alu_result_in = d;
    memtoreg_in   = 1'b0;
    @(posedge clk);
    #1;
    WVRwrite_in   = 1'b0;
    SVRwrite_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    WVRwrite_in = 1'b0;
    SVRwrite_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vr_we"},    vr_we,    0);
    check({tag, "_vr_sel"},   vr_sel,   0);
    check({tag, "_vr_waddr"}, vr_waddr, 0);
    check({tag, "_vr_wdata"}, vr_wdata, 0);
    check({tag, "_vr_busy"},  vr_busy,  0);
    check({tag, "_vr_err"},   vr_err,   0);
  endtask

  // Safety net: the directed sequence is short, so this never fires normally.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset         = 1'b1;
    readdata_in   = 32'd0;
    alu_result_in = 32'd0;
    rd_in         = 5'd0;
    memtoreg_in   = 1'b0;
    regwrite_in   = 1'b0;
    WVRwrite_in   = 1'b0;
    SVRwrite_in   = 1'b0;

    // ---- Reset state ---------------------------------------------------------
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    check_all_zero("post_reset");

    // ---- Scalar path (combinational) ----------------------------------------
    regwrite_in   = 1'b1;
    rd_in         = 5'd5;
    memtoreg_in   = 1'b1;
    readdata_in   = 32'hDEADBEEF;
    alu_result_in = 32'h12345678;
    #1;
    check("sc_we",    rf_we,    1);
    check("sc_waddr", rf_waddr, 5);
    check("sc_wdata", rf_wdata, 32'hDEADBEEF);
    memtoreg_in = 1'b0;
    #1;
    check("sc_wdata_alu", rf_wdata, 32'h12345678);
    rd_in = 5'd0;
    #1;
    check("sc_rd0_we", rf_we, 0);
    rd_in       = 5'd31;
    regwrite_in = 1'b0;
    #1;
    check("sc_nowrite_we", rf_we, 0);
    check("sc_no_vr_we",   vr_we, 0);

    // ---- Full WVR burst, rd=3 -----------------------------------------------
    beat(1'b1, 1'b0, 5'd3, 32'h11);
    check("wvr_b0_busy", vr_busy, vx(1));
    check("wvr_b0_we",   vr_we,   0);
    beat(1'b1, 1'b0, 5'd3, 32'h22);
    check("wvr_b1_busy", vr_busy, vx(1));
    beat(1'b1, 1'b0, 5'd3, 32'h33);
    check("wvr_b2_busy", vr_busy, vx(1));
    check("wvr_b2_we",   vr_we,   0);
    beat(1'b1, 1'b0, 5'd3, 32'h44);
    check("wvr_we",    vr_we,    vx(1));
    check("wvr_sel",   vr_sel,   0);
    check("wvr_waddr", vr_waddr, vx(3));
    check("wvr_wdata", vr_wdata, vx(128'h00000044_00000033_00000022_00000011));
    check("wvr_busy",  vr_busy,  0);
    idle(1);
    check("wvr_we_pulse", vr_we, 0);
    check("wvr_err",      vr_err, 0);

    // ---- SVR beats with two idle cycles between each, rd=7 ------------------
    beat(1'b0, 1'b1, 5'd7, 32'hA1);
    idle(2);
    check("svr_gap_busy", vr_busy, vx(1));
    beat(1'b0, 1'b1, 5'd7, 32'hA2);
    idle(2);
    beat(1'b0, 1'b1, 5'd7, 32'hA3);
    idle(2);
    check("svr_gap_we", vr_we, 0);
    beat(1'b0, 1'b1, 5'd7, 32'hA4);
    check("svr_we",    vr_we,    vx(1));
    check("svr_sel",   vr_sel,   vx(1));
    check("svr_waddr", vr_waddr, vx(7));
    check("svr_wdata", vr_wdata, vx(128'h000000A4_000000A3_000000A2_000000A1));
    idle(1);
    check("svr_we_pulse", vr_we, 0);

    // ---- Type violation: 2 WVR beats, then SVR restarts the sequence --------
    beat(1'b1, 1'b0, 5'd3, 32'h100);
    beat(1'b1, 1'b0, 5'd3, 32'h200);
    check("viol_pre_err", vr_err, 0);
    beat(1'b0, 1'b1, 5'd3, 32'h300);
    check("viol_err",  vr_err,  vx(1));
    check("viol_busy", vr_busy, vx(1));
    beat(1'b0, 1'b1, 5'd3, 32'h400);
    check("viol_b1_we", vr_we, 0);
    beat(1'b0, 1'b1, 5'd3, 32'h500);
    check("viol_b2_we", vr_we, 0);
    beat(1'b0, 1'b1, 5'd3, 32'h600);
    check("viol_we",    vr_we,    vx(1));
    check("viol_sel",   vr_sel,   vx(1));
    check("viol_waddr", vr_waddr, vx(3));
    check("viol_wdata", vr_wdata, vx(128'h00000600_00000500_00000400_00000300));
    idle(1);
    check("viol_err_sticky", vr_err, vx(1));

    // ---- Reset mid-sequence, then a burst to vector index 0 -----------------
    beat(1'b1, 1'b0, 5'd4, 32'hC1);
    beat(1'b1, 1'b0, 5'd4, 32'hC2);
    reset = 1'b1;
    #2;
    check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("midrst_after_we",   vr_we,   0);
    check("midrst_after_busy", vr_busy, 0);
    beat(1'b1, 1'b0, 5'd0, 32'h5);
    beat(1'b1, 1'b0, 5'd0, 32'h6);
    beat(1'b1, 1'b0, 5'd0, 32'h7);
    check("rd0_b2_we", vr_we, 0);
    beat(1'b1, 1'b0, 5'd0, 32'h8);
    check("rd0_we",    vr_we,    vx(1));
    check("rd0_waddr", vr_waddr, 0);
    check("rd0_wdata", vr_wdata, vx(128'h00000008_00000007_00000006_00000005));
    check("rd0_err",   vr_err,   0);

    // ---- Both flags high mid-sequence; scalar write alongside a beat --------
    beat(1'b1, 1'b0, 5'd9, 32'h1);
    beat(1'b1, 1'b1, 5'd9, 32'hBAD);
    check("both_err",  vr_err,  vx(1));
    check("both_busy", vr_busy, vx(1));
    regwrite_in   = 1'b1;
    WVRwrite_in   = 1'b1;
    rd_in         = 5'd9;
    alu_result_in = 32'h2;
    #1;
    check("dual_rf_we",    rf_we,    1);
    check("dual_rf_wdata", rf_wdata, 32'h2);
    @(posedge clk);
    #1;
    regwrite_in = 1'b0;
    beat(1'b1, 1'b0, 5'd9, 32'h3);
    beat(1'b1, 1'b0, 5'd9, 32'h4);
    check("both_we",    vr_we,    vx(1));
    check("both_waddr", vr_waddr, vx(9));
    check("both_wdata", vr_wdata, vx(128'h00000004_00000003_00000002_00000001));
    idle(1);
    check("final_busy", vr_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_vec_collector.md
WB_VEC_COLLECTOR -- requirements
Module: wb_vec_collector

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port readdata_in, input, 32, MEM/WB load data.
REQ-004 SHALL have port alu_result_in, input, 32, MEM/WB ALU result.
REQ-005 SHALL have port rd_in, input, 5, MEM/WB destination index.
REQ-006 SHALL have ports memtoreg_in, regwrite_in, WVRwrite_in, SVRwrite_in, input, 1 each, MEM/WB control.
REQ-007 SHALL have ports rf_we (1), rf_waddr (5), rf_wdata (32), outputs, scalar register-file write port.
REQ-008 SHALL have ports vr_we (1), vr_sel (1, 0=WVR, 1=SVR), vr_waddr (5), vr_wdata (128), outputs, vector register-file write port.
REQ-009 SHALL have port vr_busy, output, 1, partial vector collection in progress.
REQ-010 SHALL have port vr_err, output, 1, sticky sequence-violation flag.

Function
REQ-011 SHALL compute wb_data = memtoreg_in ? readdata_in : alu_result_in, combinationally.
REQ-012 SHALL drive rf_we = regwrite_in && (rd_in != 0), rf_waddr = rd_in, rf_wdata = wb_data, combinationally, zero latency.
REQ-013 SHALL treat a cycle with exactly one of WVRwrite_in/SVRwrite_in high as a vector beat carrying wb_data.
REQ-014 SHALL hold a 2-bit beat counter and a 128-bit staging buffer; beat k is stored in bits [32k+31:32k].
REQ-015 SHALL run FSM states IDLE (count 0) and COLLECT (count 1..3); IDLE->COLLECT on first beat, COLLECT->IDLE on fourth beat.
REQ-016 SHALL latch vector type (WVR/SVR) and rd_in on beat 0 of a sequence.
REQ-017 SHALL, on the clock edge sampling beat 3, register vr_we=1, vr_sel=latched type, vr_waddr=latched rd, vr_wdata=full buffer; vr_we lasts exactly one cycle.
REQ-018 SHALL allow idle cycles (no vector flag) between beats; counter and buffer hold.
REQ-019 SHALL, on a beat whose type or rd_in differs from the latched values while in COLLECT, discard the partial buffer, set vr_err, and restart with that beat as beat 0.
REQ-020 SHALL treat WVRwrite_in and SVRwrite_in both high as a violation: set vr_err, ignore the beat, state unchanged.
REQ-021 SHALL keep the scalar port independent: regwrite_in with a vector beat in the same cycle performs both.
REQ-022 SHALL drive vr_busy = 1 exactly while in COLLECT.
REQ-023 SHALL allow vector writes to index 0 (no suppression on the vector port).

Reset
REQ-024 SHALL, on reset asserted, asynchronously clear FSM to IDLE, counter, buffer, latched type/rd, vr_we, vr_sel, vr_waddr, vr_wdata, vr_err to 0.
REQ-025 SHALL discard any partial collection on reset mid-sequence; no vr_we follows.
REQ-026 SHALL clear vr_err only by reset.

Configuration
REQ-027 SHALL compile the vector collector in when macro WB_VEC_COLLECT_EN is defined.
REQ-028 SHALL, without WB_VEC_COLLECT_EN, ignore WVRwrite_in/SVRwrite_in and tie vr_we, vr_sel, vr_waddr, vr_wdata, vr_busy, vr_err to 0; the scalar path is unchanged.

Verification
REQ-029 SHALL cover scalar: regwrite=1, rd=5, memtoreg=1, readdata=0xDEADBEEF -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; rd=0 -> rf_we=0.
REQ-030 SHALL cover a full WVR burst: 4 consecutive beats rd=3, alu_result 0x11,0x22,0x33,0x44 (memtoreg=0) -> next cycle vr_we=1, vr_sel=0, vr_waddr=3, vr_wdata=0x00000044_00000033_00000022_00000011, vr_busy 1 for 3 cycles.
REQ-031 SHALL cover gaps: SVR beats with 2 idle cycles between each -> single vr_we, vr_sel=1, correct 128-bit data.
REQ-032 SHALL cover a violation: 2 WVR beats rd=3, then an SVR beat rd=3 -> vr_err=1, count restarts at 1, no vr_we until 3 more SVR beats.
REQ-033 SHALL cover reset mid-sequence: 2 beats, reset pulse -> all outputs 0, no vr_we; a subsequent 4-beat burst commits normally.
REQ-034 SHALL cover simultaneous flags: WVRwrite=SVRwrite=1 -> vr_err=1, counter unchanged; build without WB_VEC_COLLECT_EN -> vr_we never asserted.
